// File: rtl/iconn_pkg.sv
// Shared VP interconnect types: node address, port count and port index.
package iconn_pkg;

   localparam int ICONN_NODE_ADDR_WIDTH = 5;
   localparam int ICONN_PORT_NUM        = 2;

   typedef logic [ICONN_NODE_ADDR_WIDTH-1:0]  node_addr_t;
   typedef logic [$clog2(ICONN_PORT_NUM)-1:0] iconn_port_t;

endpackage

// File: rtl/iconn_split_fifo.sv
// Per-port synchronous FIFO holding {addr, data}; the head is read straight
// from the storage array so a pop exposes the next entry in the same cycle.
module iconn_split_fifo #(
   parameter int WIDTH = 69,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH for free.
   always_comb begin
      push_ok  = push_i && !full_o;
      pop_ok   = pop_i && !empty_o;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/iconn_splitter.sv
// Two-way destination splitter: steers flits by address into per-port FIFOs.
// Optional per-port push counters are enabled with ICONN_SPLITTER_STAT_EN.
module iconn_splitter
   import iconn_pkg::*;
#(
   parameter int NODE_ADDR_WIDTH = 5,
   parameter int DATA_WIDTH      = 64,
   parameter int SPLIT_ADDR      = 16,
   parameter int FIFO_DEPTH      = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [NODE_ADDR_WIDTH-1:0]   in_addr,
   input  logic [DATA_WIDTH-1:0]        in_data,
   output logic [1:0]                   out_valid,
   input  logic [1:0]                   out_ready,
   output logic [NODE_ADDR_WIDTH-1:0]   out_addr  [0:1],
   output logic [DATA_WIDTH-1:0]        out_data  [0:1],
   output logic [$clog2(FIFO_DEPTH):0]  out_count [0:1]
`ifdef ICONN_SPLITTER_STAT_EN
   ,
   input  logic                         stat_clr,
   output logic [31:0]                  stat_flits [0:1]
`endif
);

   localparam int FW = NODE_ADDR_WIDTH + DATA_WIDTH;
   localparam logic [NODE_ADDR_WIDTH-1:0] SPLIT = NODE_ADDR_WIDTH'(SPLIT_ADDR);

   iconn_port_t  sel;
   logic [1:0]   full, empty, push, pop;
   logic [FW-1:0] head [ICONN_PORT_NUM];

   assign sel = (in_addr < SPLIT) ? iconn_port_t'(0) : iconn_port_t'(1);

   // Depends only on the (held-stable) address and full, never on out_ready.
   assign in_ready = !full[sel];

   for (genvar p = 0; p < ICONN_PORT_NUM; p++) begin : g_port
      assign push[p]      = in_valid && in_ready && (sel == iconn_port_t'(p));
      assign pop[p]       = out_valid[p] && out_ready[p];
      assign out_valid[p] = !empty[p];
      assign {out_addr[p], out_data[p]} = head[p];

      iconn_split_fifo #(
         .WIDTH (FW),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst_n   (rst_n),
         .push_i  (push[p]),
         .wdata_i ({in_addr, in_data}),
         .pop_i   (pop[p]),
         .rdata_o (head[p]),
         .full_o  (full[p]),
         .empty_o (empty[p]),
         .count_o (out_count[p])
      );
   end

`ifdef ICONN_SPLITTER_STAT_EN
   logic [31:0] stat_q [ICONN_PORT_NUM];

   // Clear wins over a same-cycle push; counters stick at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ICONN_PORT_NUM; i++) stat_q[i] <= '0;
      end else begin
         for (int i = 0; i < ICONN_PORT_NUM; i++) begin
            if (stat_clr)
               stat_q[i] <= '0;
            else if (push[i] && (stat_q[i] != '1))
               stat_q[i] <= stat_q[i] + 32'd1;
         end
      end
   end

   assign stat_flits[0] = stat_q[0];
   assign stat_flits[1] = stat_q[1];
`endif

endmodule

// File: tb/tb_iconn_splitter.sv
// Directed self-checking bench for iconn_splitter (default parameters).
module tb_iconn_splitter;

   localparam int AW = 5;
   localparam int DW = 64;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_addr;
   logic [DW-1:0] in_data;
   logic [1:0]    out_valid;
   logic [1:0]    out_ready;
   logic [AW-1:0] out_addr  [0:1];
   logic [DW-1:0] out_data  [0:1];
   logic [CW-1:0] out_count [0:1];
`ifdef ICONN_SPLITTER_STAT_EN
   logic          stat_clr;
   logic [31:0]   stat_flits [0:1];
`endif

   int total = 0;
   int bad   = 0;
   logic [DW-1:0] exp_q [$];

   always #5 clk = ~clk;

   iconn_splitter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_addr   (in_addr),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_data  (out_data),
      .out_count (out_count)
`ifdef ICONN_SPLITTER_STAT_EN
      ,
      .stat_clr  (stat_clr),
      .stat_flits(stat_flits)
`endif
   );

   // Drive one flit and hold it until accepted, bounded to 20 cycles.
   task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      in_addr  = a;
      in_data  = d;
      in_valid = 1'b1;
      #1;
      while (in_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL send_timeout addr=%0d in_ready=%b want 1", a, in_ready);
         in_valid = 1'b0;
      end else begin
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; out_ready = 2'b00;
`ifdef ICONN_SPLITTER_STAT_EN
      stat_clr = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      total++; if (out_valid !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b want=00", out_valid); end
      total++; if (out_count[0] !== 2'd0 || out_count[1] !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d,%0d want 0,0", out_count[0], out_count[1]); end
      total++; if (out_data[0] !== '0 || out_data[1] !== '0) begin bad++; $display("FAIL reset_data got=%h,%h want 0", out_data[0], out_data[1]); end
      total++; if (out_addr[0] !== '0 || out_addr[1] !== '0) begin bad++; $display("FAIL reset_addr got=%0d,%0d want 0", out_addr[0], out_addr[1]); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_first();
      out_ready = 2'b11;
      in_addr = 5'd3; in_data = 64'hA5; in_valid = 1'b1;
      #1;
      total++; if (out_valid !== 2'b00) begin bad++; $display("FAIL first_no_bypass got=%b want=00", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL first_ready got=%b want=1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++; if (out_valid !== 2'b01) begin bad++; $display("FAIL first_valid got=%b want=01", out_valid); end
      total++; if (out_data[0] !== 64'hA5) begin bad++; $display("FAIL first_data got=%h want=a5", out_data[0]); end
      total++; if (out_addr[0] !== 5'd3) begin bad++; $display("FAIL first_addr got=%0d want=3", out_addr[0]); end
      @(posedge clk); #1;
      total++; if (out_valid !== 2'b00 || out_count[0] !== 2'd0) begin bad++; $display("FAIL first_drain valid=%b cnt=%0d want 00,0", out_valid, out_count[0]); end
   endtask

   task automatic test_route();
      out_ready = 2'b00;
      send(5'd16, 64'h10);
      send(5'd31, 64'h1F);
      send(5'd15, 64'h0F);
      total++; if (out_count[1] !== 2'd2) begin bad++; $display("FAIL route_cnt1 got=%0d want=2", out_count[1]); end
      total++; if (out_count[0] !== 2'd1) begin bad++; $display("FAIL route_cnt0 got=%0d want=1", out_count[0]); end
      total++; if (out_data[1] !== 64'h10 || out_addr[1] !== 5'd16) begin bad++; $display("FAIL route_p1_head got=%h@%0d want 10@16", out_data[1], out_addr[1]); end
      total++; if (out_data[0] !== 64'h0F || out_addr[0] !== 5'd15) begin bad++; $display("FAIL route_p0_head got=%h@%0d want 0f@15", out_data[0], out_addr[0]); end
      out_ready = 2'b10;
      @(posedge clk); #1;
      total++; if (out_data[1] !== 64'h1F || out_addr[1] !== 5'd31) begin bad++; $display("FAIL route_p1_second got=%h@%0d want 1f@31", out_data[1], out_addr[1]); end
      @(posedge clk); #1;
      total++; if (out_valid !== 2'b01) begin bad++; $display("FAIL route_p1_drained got=%b want=01", out_valid); end
      out_ready = 2'b01;
      @(posedge clk); #1;
      out_ready = 2'b00;
      total++; if (out_valid !== 2'b00) begin bad++; $display("FAIL route_all_drained got=%b want=00", out_valid); end
   endtask

   task automatic test_full();
      out_ready = 2'b00;
      send(5'd2, 64'd1);
      send(5'd2, 64'd2);
      total++; if (out_count[0] !== 2'd2) begin bad++; $display("FAIL full_cnt got=%0d want=2", out_count[0]); end
      in_addr = 5'd2; in_data = 64'd3; in_valid = 1'b1;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", in_ready); end
      in_valid = 1'b0;
      send(5'd20, 64'h20);
      total++; if (out_valid !== 2'b11 || out_count[1] !== 2'd1) begin bad++; $display("FAIL full_other_port valid=%b cnt1=%0d want 11,1", out_valid, out_count[1]); end
      total++; if (out_data[1] !== 64'h20) begin bad++; $display("FAIL full_other_data got=%h want=20", out_data[1]); end
      out_ready = 2'b10;
      @(posedge clk); #1;
      out_ready = 2'b00;
      total++; if (out_valid !== 2'b01) begin bad++; $display("FAIL full_other_drain got=%b want=01", out_valid); end
   endtask

   task automatic test_full_pop();
      total++; if (out_data[0] !== 64'd1) begin bad++; $display("FAIL fpop_head1 got=%0d want=1", out_data[0]); end
      in_addr = 5'd2; in_data = 64'd3; in_valid = 1'b1;
      out_ready = 2'b01;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fpop_no_passthru got=%b want=0", in_ready); end
      @(posedge clk); #1;
      out_ready = 2'b00;
      total++; if (out_data[0] !== 64'd2 || out_count[0] !== 2'd1) begin bad++; $display("FAIL fpop_after_pop data=%0d cnt=%0d want 2,1", out_data[0], out_count[0]); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fpop_ready got=%b want=1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++; if (out_count[0] !== 2'd2) begin bad++; $display("FAIL fpop_cnt got=%0d want=2", out_count[0]); end
      out_ready = 2'b01;
      total++; if (out_data[0] !== 64'd2) begin bad++; $display("FAIL fpop_order2 got=%0d want=2", out_data[0]); end
      @(posedge clk); #1;
      total++; if (out_data[0] !== 64'd3 || out_count[0] !== 2'd1) begin bad++; $display("FAIL fpop_order3 data=%0d cnt=%0d want 3,1", out_data[0], out_count[0]); end
      @(posedge clk); #1;
      out_ready = 2'b00;
      total++; if (out_valid[0] !== 1'b0) begin bad++; $display("FAIL fpop_drained got=%b want=0", out_valid[0]); end
   endtask

   task automatic test_back_to_back();
      out_ready = 2'b10;
      for (int i = 0; i < 8; i++) begin
         in_addr = AW'(16 + i); in_data = 64'h100 + 64'(i); in_valid = 1'b1;
         exp_q.push_back(64'h100 + 64'(i));
         @(posedge clk); #1;
         total++; if (out_data[1] !== exp_q[0]) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", i, out_data[1], exp_q[0]); end
         total++; if (out_count[1] !== 2'd1) begin bad++; $display("FAIL b2b_cnt[%0d] got=%0d want=1", i, out_count[1]); end
         void'(exp_q.pop_front());
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 2'b00;
      total++; if (out_valid !== 2'b00 || out_count[1] !== 2'd0) begin bad++; $display("FAIL b2b_end valid=%b cnt=%0d want 00,0", out_valid, out_count[1]); end
   endtask

   task automatic test_async_reset();
      out_ready = 2'b00;
      send(5'd1, 64'hAA);
      send(5'd2, 64'hBB);
      total++; if (out_count[0] !== 2'd2) begin bad++; $display("FAIL arst_pre_cnt got=%0d want=2", out_count[0]); end
      #3;
      rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 2'b00) begin bad++; $display("FAIL arst_valid got=%b want=00", out_valid); end
      total++; if (out_count[0] !== 2'd0) begin bad++; $display("FAIL arst_cnt got=%0d want=0", out_count[0]); end
      total++; if (out_data[0] !== '0) begin bad++; $display("FAIL arst_data got=%h want=0", out_data[0]); end
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (out_valid !== 2'b00) begin bad++; $display("FAIL arst_post got=%b want=00", out_valid); end
   endtask

`ifdef ICONN_SPLITTER_STAT_EN
   task automatic test_stat();
      total++; if (stat_flits[0] !== 32'd0 || stat_flits[1] !== 32'd0) begin bad++; $display("FAIL stat_reset got=%0d,%0d want 0,0", stat_flits[0], stat_flits[1]); end
      out_ready = 2'b11;
      send(5'd4, 64'h44);
      total++; if (stat_flits[0] !== 32'd1 || stat_flits[1] !== 32'd0) begin bad++; $display("FAIL stat_count got=%0d,%0d want 1,0", stat_flits[0], stat_flits[1]); end
      stat_clr = 1'b1;
      @(posedge clk); #1;
      stat_clr = 1'b0;
      out_ready = 2'b00;
      total++; if (stat_flits[0] !== 32'd0) begin bad++; $display("FAIL stat_clr got=%0d want=0", stat_flits[0]); end
   endtask
`endif

   initial begin
      test_reset();
      test_first();
      test_route();
      test_full();
      test_full_pop();
      test_back_to_back();
      test_async_reset();
`ifdef ICONN_SPLITTER_STAT_EN
      test_stat();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
